regfile_wr_arbiter: RTL and testbench

Shares the register file's single write port between three writeback sources: the in-order pipeline WB stage (port 0), the load unit (port 1) and the multicycle mul/div unit (port 2). It arbitrates per cycle, registers the winning write onto the regfile write port (`we`/`wa`/`wd`), and bounds starvation of the slow units. It also exports a pending-write mask so ID can stall on registers whose writeback has not yet been granted.

---
 rtl/regfile_wr_arbiter.sv | 114 +++++++++++
 tb/tb_regfile_wr_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Three-source write-port arbiter for the register file.
// Slow units that keep losing become urgent; a registered write drives the regfile.

module regfile_wr_wait_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic cpu_clk_50M,
  input  logic cpu_rst,
  input  logic req,
  input  logic ack,
  output logic urgent
);
  logic [3:0] cnt;

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst)
    if (cpu_rst)                      cnt <= '0;
    else if (!req || ack)             cnt <= '0;
    else if (cnt != 4'(STARVE_MAX))   cnt <= cnt + 4'd1;

  assign urgent = req && (cnt == 4'(STARVE_MAX));
endmodule

module regfile_wr_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic [2:0]        req,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [ADDR_W-1:0] wa2,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  input  logic [DATA_W-1:0] wd2,
  output logic [2:0]        ack,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic [DATA_W-1:0] wd,
  output logic [1:0]        grant_id,
  output logic [31:0]       busy_mask
);
  logic [2:0][ADDR_W-1:0] wa_all;
  logic [2:0][DATA_W-1:0] wd_all;
  logic [1:0]             urgent;   // bit k belongs to port k+1
  logic                   rr_ptr;   // 0 -> port 1 next, 1 -> port 2 next
  logic [2:0]             ack_c;
  logic [1:0]             gid_c;

  assign wa_all = {wa2, wa1, wa0};
  assign wd_all = {wd2, wd1, wd0};

  for (genvar k = 0; k < 2; k++) begin : g_wait
    regfile_wr_wait_cnt #(.STARVE_MAX(STARVE_MAX)) u_wait (
      .cpu_clk_50M (cpu_clk_50M),
      .cpu_rst     (cpu_rst),
      .req         (req[k+1]),
      .ack         (ack_c[k+1]),
      .urgent      (urgent[k])
    );
  end

  always_comb begin
    ack_c = '0;
    if (urgent == 2'b11)      ack_c = rr_ptr ? 3'b100 : 3'b010;
    else if (urgent[0])       ack_c = 3'b010;
    else if (urgent[1])       ack_c = 3'b100;
    else if (req[0])          ack_c = 3'b001;
    else if (req[2:1] == 2'b11) ack_c = rr_ptr ? 3'b100 : 3'b010;
    else if (req[1])          ack_c = 3'b010;
    else if (req[2])          ack_c = 3'b100;
    if (cpu_rst) ack_c = '0;
  end

  always_comb begin
    gid_c = 2'd3;
    if (ack_c[0])      gid_c = 2'd0;
    else if (ack_c[1]) gid_c = 2'd1;
    else if (ack_c[2]) gid_c = 2'd2;
  end

  assign ack = ack_c;

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst)
    if (cpu_rst) begin
      we       <= 1'b0;
      wa       <= '0;
      wd       <= '0;
      grant_id <= 2'd3;
      rr_ptr   <= 1'b0;
    end else begin
      if (|ack_c) begin
        // r0 writes still consume a grant but never reach the regfile
        we       <= (wa_all[gid_c] != '0);
        wa       <= wa_all[gid_c];
        wd       <= wd_all[gid_c];
        grant_id <= gid_c;
      end else begin
        we       <= 1'b0;
        wa       <= '0;
        wd       <= '0;
        grant_id <= 2'd3;
      end
      if (ack_c[1])      rr_ptr <= 1'b1;
      else if (ack_c[2]) rr_ptr <= 1'b0;
    end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < 3; i++)
      if (req[i] && wa_all[i] != '0) busy_mask[wa_all[i]] = 1'b1;
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized and directed checks of regfile_wr_arbiter against a cycle-level
// reference model of the arbitration rules and a shadow register file.
module tb_regfile_wr_arbiter;
  localparam int SM = 4;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst;
  logic [2:0]  req;
  logic [4:0]  wa_v [3];
  logic [31:0] wd_v [3];
  logic [4:0]  wa0, wa1, wa2;
  logic [31:0] wd0, wd1, wd2;
  logic [2:0]  ack;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [1:0]  grant_id;
  logic [31:0] busy_mask;

  assign wa0 = wa_v[0]; assign wa1 = wa_v[1]; assign wa2 = wa_v[2];
  assign wd0 = wd_v[0]; assign wd1 = wd_v[1]; assign wd2 = wd_v[2];

  regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(SM)) dut (
    .cpu_clk_50M (cpu_clk_50M), .cpu_rst (cpu_rst), .req (req),
    .wa0 (wa0), .wa1 (wa1), .wa2 (wa2), .wd0 (wd0), .wd1 (wd1), .wd2 (wd2),
    .ack (ack), .we (we), .wa (wa), .wd (wd), .grant_id (grant_id),
    .busy_mask (busy_mask)
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  // regfile as seen through the DUT's write port
  logic [31:0] tb_rf [32];
  always @(posedge cpu_clk_50M) if (we) tb_rf[wa] <= wd;

  int total = 0, bad = 0;
  int mcnt [3];
  int rr_next;
  logic        exp_we;
  logic [4:0]  exp_wa;
  logic [31:0] exp_wd;
  int          exp_gid;
  logic [31:0] mrf [32];
  logic [2:0]  ack_seen;
  logic [31:0] busy_seen;
  int          last_g;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mcnt[1] = 0; mcnt[2] = 0; rr_next = 1;
    exp_we = 1'b0; exp_wa = '0; exp_wd = '0; exp_gid = 3;
  endtask

  function automatic int model_pick(logic [2:0] r);
    bit u1, u2;
    u1 = r[1] && mcnt[1] == SM;
    u2 = r[2] && mcnt[2] == SM;
    if (u1 && u2) return rr_next;
    if (u1) return 1;
    if (u2) return 2;
    if (r[0]) return 0;
    if (r[1] && r[2]) return rr_next;
    if (r[1]) return 1;
    if (r[2]) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] model_busy(logic [2:0] r);
    logic [31:0] m = '0;
    for (int p = 0; p < 3; p++) if (r[p] && wa_v[p] != 0) m[wa_v[p]] = 1'b1;
    return m;
  endfunction

  // one clock: called at a falling edge with inputs already set
  task automatic cycle();
    int g;
    chk("we", 32'(we), 32'(exp_we));
    chk("wa", 32'(wa), 32'(exp_wa));
    chk("wd", wd, exp_wd);
    chk("grant_id", 32'(grant_id), 32'(exp_gid));
    if (exp_we) mrf[exp_wa] = exp_wd;
    #1;
    g = model_pick(req);
    chk("ack", 32'(ack), (g == 3) ? 32'd0 : (32'd1 << g));
    chk("busy_mask", busy_mask, model_busy(req));
    ack_seen = ack; busy_seen = busy_mask; last_g = g;
    for (int p = 1; p < 3; p++)
      mcnt[p] = (req[p] && g != p) ? ((mcnt[p] + 1 > SM) ? SM : mcnt[p] + 1) : 0;
    if (g == 1) rr_next = 2; else if (g == 2) rr_next = 1;
    if (g != 3) begin
      exp_we = (wa_v[g] != 0); exp_wa = wa_v[g]; exp_wd = wd_v[g]; exp_gid = g;
    end else begin
      exp_we = 1'b0; exp_wa = '0; exp_wd = '0; exp_gid = 3;
    end
    @(negedge cpu_clk_50M);
  endtask

  task automatic set_port(input int p, input logic r, input logic [4:0] a, input logic [31:0] d);
    req[p] = r; wa_v[p] = a; wd_v[p] = d;
  endtask

  initial begin
    int seq [6] = '{0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 32; i++) begin tb_rf[i] = '0; mrf[i] = '0; end
    cpu_rst = 1'b1; req = '0;
    for (int p = 0; p < 3; p++) begin wa_v[p] = '0; wd_v[p] = '0; end
    model_reset();
    #5;
    chk("rst_we", 32'(we), 0);
    chk("rst_wa", 32'(wa), 0);
    chk("rst_wd", wd, 0);
    chk("rst_gid", 32'(grant_id), 3);
    chk("rst_ack", 32'(ack), 0);
    @(negedge cpu_clk_50M); @(negedge cpu_clk_50M);
    cpu_rst = 1'b0;

    // single port
    set_port(0, 1, 5'd5, 32'hDEADBEEF);
    cycle();
    chk("sp_ack", 32'(ack_seen), 32'b001);
    chk("sp_we", 32'(we), 1); chk("sp_wa", 32'(wa), 5);
    chk("sp_wd", wd, 32'hDEADBEEF); chk("sp_gid", 32'(grant_id), 0);
    req = '0;
    cycle();
    chk("sp_idle_we", 32'(we), 0); chk("sp_idle_gid", 32'(grant_id), 3);

    // round robin between the slow ports
    set_port(1, 1, 5'd3, 32'h11); set_port(2, 1, 5'd9, 32'h22);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr_ack", 32'(ack_seen), (i % 2 == 0) ? 32'b010 : 32'b100);
      chk("rr_busy", busy_seen, 32'h0000_0208);
    end
    req = '0; cycle();

    // starvation of port 1 under continuous port-0 traffic
    for (int i = 0; i < 6; i++) begin
      set_port(0, 1, 5'(10 + i), 32'(i));
      set_port(1, i <= 4, 5'd12, 32'hCAFE);
      cycle();
      chk("starve_ack", 32'(ack_seen), 32'd1 << seq[i]);
    end
    req = '0; cycle();

    // r0 write
    set_port(2, 1, 5'd0, 32'h1234);
    cycle();
    chk("r0_ack", 32'(ack_seen), 32'b100);
    chk("r0_busy", busy_seen, 0);
    chk("r0_we", 32'(we), 0); chk("r0_gid", 32'(grant_id), 2);
    req = '0; cycle();

    // same address from two ports
    set_port(0, 1, 5'd7, 32'd1); set_port(1, 1, 5'd7, 32'd2);
    cycle();
    chk("sa_ack0", 32'(ack_seen), 32'b001);
    req[0] = 1'b0;
    cycle();
    chk("sa_ack1", 32'(ack_seen), 32'b010);
    req = '0; cycle(); cycle();
    chk("sa_r7", tb_rf[7], 32'd2);

    // reset while a write is on the port
    set_port(0, 1, 5'd3, 32'hAAAA); set_port(1, 1, 5'd4, 32'hBBBB);
    cycle();
    chk("mr_ack", 32'(ack_seen), 32'b001);
    cpu_rst = 1'b1; req[0] = 1'b0;
    #1;
    chk("mr_we", 32'(we), 0); chk("mr_wa", 32'(wa), 0);
    chk("mr_wd", wd, 0); chk("mr_gid", 32'(grant_id), 3);
    chk("mr_ackoff", 32'(ack), 0);
    model_reset();
    @(negedge cpu_clk_50M); @(negedge cpu_clk_50M);
    cpu_rst = 1'b0;
    cycle();
    chk("mr_post_ack", 32'(ack_seen), 32'b010);
    req = '0; cycle();

    // randomized traffic obeying the request/ack handshake
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 3; p++)
        if (!req[p] || last_g == p)
          set_port(p, $urandom_range(0, 99) < 65, 5'($urandom_range(0, 7)), $urandom);
      cycle();
    end
    req = '0; cycle(); cycle(); cycle();
    for (int r = 0; r < 32; r++) chk("rf", tb_rf[r], mrf[r]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
